// File: rtl/sram_bist_ctrl.sv
// March-style SRAM BIST controller: W0 (write background), R0W1 (read
// background then write its inverse, ascending), R1 (read inverse,
// descending), DRAIN (last compare). Memory outputs are registered.
module sram_bist_ctrl #(
  parameter int unsigned        BW_DATA = 64,
  parameter int unsigned        BW_ADDR = 6,
  parameter logic [BW_DATA-1:0] PATTERN = {BW_DATA/2{2'b01}}
) (
  input  logic               i_clk,
  input  logic               i_rstn,
  input  logic               i_start,
  input  logic [BW_DATA-1:0] i_mem_data,
  output logic [BW_DATA-1:0] o_mem_data,
  output logic [BW_ADDR-1:0] o_mem_addr,
  output logic               o_mem_cen,
  output logic               o_mem_wen,
  output logic               o_mem_oen,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_fail,
  output logic [BW_ADDR-1:0] o_fail_addr,
  output logic [BW_ADDR+1:0] o_err_cnt
);

  typedef enum logic [2:0] {IDLE, W0, R0W1, R1, DRAIN, DONE} state_t;

  localparam logic [BW_ADDR-1:0] ADDR_MAX = '1;

  state_t             state_q, state_d;
  logic [BW_ADDR-1:0] addr_d;
  logic               sub_q, sub_d;     // R0W1: 0 = read half, 1 = write half
  logic               rd_pend_q;        // an R1 read was issued last cycle
  logic [BW_ADDR-1:0] rd_addr_q;        // address of that R1 read
  logic               clear;
  logic               cen_d, wen_d, oen_d;
  logic [BW_DATA-1:0] wdata_d;
  logic               cmp_r0w1;
  logic [BW_DATA-1:0] cmp_exp;
  logic [BW_ADDR-1:0] cmp_addr;
  logic               mismatch;

  // Next-state, next-address and next memory-control decode
  always_comb begin
    state_d = state_q;
    addr_d  = o_mem_addr;
    sub_d   = sub_q;
    clear   = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (i_start) begin
          state_d = W0;
          addr_d  = '0;
          sub_d   = 1'b0;
          clear   = 1'b1;
        end
      end
      W0: begin
        if (o_mem_addr == ADDR_MAX) begin
          state_d = R0W1;
          addr_d  = '0;
          sub_d   = 1'b0;
        end else begin
          addr_d = o_mem_addr + 1'b1;
        end
      end
      R0W1: begin
        if (!sub_q) begin
          sub_d = 1'b1;
        end else if (o_mem_addr == ADDR_MAX) begin
          state_d = R1;
          addr_d  = ADDR_MAX;
          sub_d   = 1'b0;
        end else begin
          addr_d = o_mem_addr + 1'b1;
          sub_d  = 1'b0;
        end
      end
      R1: begin
        if (o_mem_addr == '0) begin
          state_d = DRAIN;
        end else begin
          addr_d = o_mem_addr - 1'b1;
        end
      end
      DRAIN:   state_d = DONE;
      default: state_d = IDLE;
    endcase

    cen_d   = (state_d == W0) || (state_d == R0W1) || (state_d == R1);
    wen_d   = (state_d == W0) || ((state_d == R0W1) && sub_d);
    oen_d   = (state_d == R1) || ((state_d == R0W1) && !sub_d);
    wdata_d = '0;
    if (state_d == W0)
      wdata_d = PATTERN;
    else if ((state_d == R0W1) && sub_d)
      wdata_d = ~PATTERN;
  end

  // Read data lands one cycle after the access: R0W1 checks it during its
  // write half, R1 checks it one cycle later against the delayed address.
  always_comb begin
    cmp_r0w1 = (state_q == R0W1) && sub_q;
    cmp_exp  = cmp_r0w1 ? PATTERN : ~PATTERN;
    cmp_addr = cmp_r0w1 ? o_mem_addr : rd_addr_q;
    mismatch = (cmp_r0w1 || rd_pend_q) && (i_mem_data != cmp_exp);
  end

  // State, address and registered memory interface
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q    <= IDLE;
      sub_q      <= 1'b0;
      o_mem_addr <= '0;
      o_mem_data <= '0;
      o_mem_cen  <= 1'b0;
      o_mem_wen  <= 1'b0;
      o_mem_oen  <= 1'b0;
      rd_pend_q  <= 1'b0;
      rd_addr_q  <= '0;
    end else begin
      state_q    <= state_d;
      sub_q      <= sub_d;
      o_mem_addr <= addr_d;
      o_mem_data <= wdata_d;
      o_mem_cen  <= cen_d;
      o_mem_wen  <= wen_d;
      o_mem_oen  <= oen_d;
      rd_pend_q  <= (state_q == R1);
      rd_addr_q  <= o_mem_addr;
    end
  end

  // Result flags: cleared on an accepted start, updated on each mismatch
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      o_fail      <= 1'b0;
      o_fail_addr <= '0;
      o_err_cnt   <= '0;
    end else if (clear) begin
      o_fail      <= 1'b0;
      o_fail_addr <= '0;
      o_err_cnt   <= '0;
    end else if (mismatch) begin
      o_err_cnt <= o_err_cnt + 1'b1;
      if (!o_fail) begin
        o_fail      <= 1'b1;
        o_fail_addr <= cmp_addr;
      end
    end
  end

  // Status decode from the state register
  always_comb begin
    o_busy = (state_q == W0) || (state_q == R0W1) || (state_q == R1) || (state_q == DRAIN);
    o_done = (state_q == DONE);
  end

endmodule

// File: tb/tb_sram_bist_ctrl.sv
// Bench for sram_bist_ctrl: behavioural SRAM with injectable faults, a
// scoreboard of expected run results and a monitor that checks every access.
module tb_sram_bist_ctrl;

  localparam int unsigned BW_DATA = 64;
  localparam int unsigned BW_ADDR = 6;
  localparam logic [BW_DATA-1:0] PAT = {BW_DATA/2{2'b01}};

  logic               clk, rstn, start;
  logic [BW_DATA-1:0] mem_rdata, mem_wdata;
  logic [BW_ADDR-1:0] mem_addr, fail_addr;
  logic               mem_cen, mem_wen, mem_oen;
  logic               busy, done, fail;
  logic [BW_ADDR+1:0] err_cnt;

  typedef struct {
    int unsigned        len;
    logic               fail;
    logic [BW_ADDR-1:0] addr;
    logic [BW_ADDR+1:0] cnt;
  } exp_t;

  exp_t        sb_q[$];
  int unsigned checks   = 0;
  int unsigned failures = 0;
  int unsigned fault    = 0;   // 0 none, 1 bit0 stuck-at-1 @0x12, 2 all-zero @0x3F

  logic [BW_DATA-1:0] mem [2**BW_ADDR];

  sram_bist_ctrl #(
    .BW_DATA (BW_DATA),
    .BW_ADDR (BW_ADDR)
  ) dut (
    .i_clk       (clk),
    .i_rstn      (rstn),
    .i_start     (start),
    .i_mem_data  (mem_rdata),
    .o_mem_data  (mem_wdata),
    .o_mem_addr  (mem_addr),
    .o_mem_cen   (mem_cen),
    .o_mem_wen   (mem_wen),
    .o_mem_oen   (mem_oen),
    .o_busy      (busy),
    .o_done      (done),
    .o_fail      (fail),
    .o_fail_addr (fail_addr),
    .o_err_cnt   (err_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Synchronous SRAM model: read data valid the cycle after the access
  always @(posedge clk) begin
    if (mem_cen) begin
      if (mem_wen) begin
        mem[mem_addr] <= mem_wdata;
      end else begin
        logic [BW_DATA-1:0] v;
        v = mem[mem_addr];
        if (fault == 1 && mem_addr == 6'h12) v[0] = 1'b1;
        if (fault == 2 && mem_addr == 6'h3F) v = '0;
        mem_rdata <= v;
      end
    end
  end

  // Monitor: protocol, access sequence and end-of-run scoreboard compare
  int unsigned busy_cnt = 0;
  int unsigned seq_err  = 0;
  logic        prev_busy = 1'b0;
  logic        prev_done = 1'b0;

  always @(negedge clk) begin
    if (!rstn) begin
      busy_cnt  = 0;
      seq_err   = 0;
      prev_busy = 1'b0;
      prev_done = 1'b0;
    end else begin
      if (mem_oen && !(mem_cen && !mem_wen))
        chk("oen_protocol", {mem_cen, mem_wen, mem_oen}, 3'b101);
      if (!busy && (mem_cen || mem_wen || mem_oen))
        chk("idle_ctrl_zero", {mem_cen, mem_wen, mem_oen}, 3'b000);
      if (busy) begin
        logic               e_cen, e_wen, e_oen;
        logic [BW_ADDR-1:0] e_addr;
        logic [BW_DATA-1:0] e_data;
        int unsigned        k, j;
        if (!prev_busy) begin
          busy_cnt = 0;
          seq_err  = 0;
        end
        k = busy_cnt;
        e_cen = 1'b1; e_wen = 1'b0; e_oen = 1'b0; e_addr = '0; e_data = '0;
        if (k < 64) begin
          e_wen = 1'b1; e_addr = k[BW_ADDR-1:0]; e_data = PAT;
        end else if (k < 192) begin
          j = k - 64;
          e_addr = j[BW_ADDR:1];
          if (j[0]) begin
            e_wen = 1'b1; e_data = ~PAT;
          end else begin
            e_oen = 1'b1;
          end
        end else if (k < 256) begin
          j = 255 - k;
          e_addr = j[BW_ADDR-1:0]; e_oen = 1'b1;
        end else begin
          e_cen = 1'b0;
        end
        if ({mem_cen, mem_wen, mem_oen} != {e_cen, e_wen, e_oen})
          seq_err++;
        else if (e_cen && mem_addr != e_addr)
          seq_err++;
        else if (e_cen && e_wen && mem_wdata != e_data)
          seq_err++;
        busy_cnt++;
      end
      if (done && !prev_done) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          chk("busy_len",   busy_cnt, e.len);
          chk("access_seq", seq_err, 0);
          chk("fail",       fail, e.fail);
          chk("fail_addr",  fail_addr, e.addr);
          chk("err_cnt",    err_cnt, e.cnt);
        end
      end
      prev_busy = busy;
      prev_done = done;
    end
  end

  task automatic push(input logic f, input logic [BW_ADDR-1:0] a, input logic [BW_ADDR+1:0] c);
    exp_t e;
    e.len = 257; e.fail = f; e.addr = a; e.cnt = c;
    sb_q.push_back(e);
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic wait_done(input int unsigned budget);
    int unsigned n = 0;
    while (!done && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (!done) chk("done_timeout", 0, 1);
  endtask

  initial begin
    int unsigned cen_seen;
    rstn = 1'b0; start = 1'b0; mem_rdata = '0;
    repeat (3) @(negedge clk);
    chk("reset_state", {busy, done, fail, fail_addr, err_cnt, mem_cen, mem_wen, mem_oen, mem_addr, |mem_wdata}, 0);
    rstn = 1'b1;
    repeat (5) @(negedge clk);
    chk("no_access_before_start", {busy, mem_cen}, 0);

    // healthy memory, with a start pulse during the run that must be ignored
    fault = 0;
    push(1'b0, 6'h00, 8'd0);
    pulse_start();
    chk("busy_after_start", busy, 1);
    repeat (50) @(negedge clk);
    pulse_start();
    wait_done(400);
    repeat (5) @(negedge clk);
    chk("done_hold", {done, busy, fail, err_cnt}, {1'b1, 1'b0, 1'b0, 8'd0});

    // stuck-at-1 on bit 0 at 0x12: only the inverted-background read fails
    fault = 1;
    push(1'b1, 6'h12, 8'd1);
    pulse_start();
    wait_done(400);

    // address 0x3F reads as zero: both read passes fail
    fault = 2;
    push(1'b1, 6'h3F, 8'd2);
    pulse_start();
    wait_done(400);
    repeat (3) @(negedge clk);
    chk("result_hold", {done, fail, fail_addr, err_cnt}, {1'b1, 1'b1, 6'h3F, 8'd2});

    // asynchronous reset 100 cycles into a run
    fault = 1;
    pulse_start();
    repeat (99) @(negedge clk);
    @(posedge clk); #2 rstn = 1'b0;
    #1 chk("async_reset_outputs", {busy, done, fail, fail_addr, err_cnt, mem_cen, mem_wen, mem_oen, mem_addr, |mem_wdata}, 0);
    @(negedge clk); rstn = 1'b1;
    cen_seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (mem_cen || busy) cen_seen++;
    end
    chk("no_access_after_reset", cen_seen, 0);

    // start held high: one run at a time, restart from DONE clears flags
    push(1'b1, 6'h12, 8'd1);
    push(1'b1, 6'h12, 8'd1);
    @(negedge clk); start = 1'b1;
    wait_done(400);
    chk("done_with_fail", {done, fail}, 2'b11);
    @(negedge clk);
    chk("restart_clears", {busy, done, fail, fail_addr, err_cnt}, {1'b1, 1'b0, 1'b0, 6'h00, 8'd0});
    start = 1'b0;
    wait_done(400);
    repeat (3) @(negedge clk);
    chk("stays_done", {done, busy}, 2'b10);
    chk("scoreboard_empty", sb_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
